// File: rtl/portfolio_ledger_if.sv
// Trade/price bus between the price generator, the trader and the ledger.
interface portfolio_ledger_if;
  logic        price_valid;
  logic [7:0]  price;
  logic        buy_req;
  logic        sell_req;
  logic [3:0]  qty;
  logic        busy;
  logic        trade_ok;
  logic        trade_reject;
  logic [15:0] cash;
  logic [7:0]  shares;
  logic [16:0] net_worth;

  modport master (
    output price_valid, price, buy_req, sell_req, qty,
    input  busy, trade_ok, trade_reject, cash, shares, net_worth
  );

  modport slave (
    input  price_valid, price, buy_req, sell_req, qty,
    output busy, trade_ok, trade_reject, cash, shares, net_worth
  );
endinterface

// File: rtl/portfolio_ledger.sv
// Cash/share ledger: shift-add priced trades, accept/reject checks and
// net worth revaluation whenever the holding or the stock price changes.
module portfolio_ledger #(
  parameter logic [15:0] START_CASH = 16'd1000
) (
  input  logic               clock_50,
  input  logic               reset,
  portfolio_ledger_if.slave  bus
);

  localparam int unsigned CASH_W  = 16;
  localparam int unsigned SHR_W   = 8;
  localparam int unsigned PRICE_W = 8;
  localparam int unsigned QTY_W   = 4;
  localparam int unsigned COST_W  = 12;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned NET_W   = 17;

  typedef enum logic [1:0] {IDLE, MUL_TRADE, DECIDE, VALUE} state_t;

  state_t               state;
  logic [2:0]           cnt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     mcand;
  logic [SHR_W-1:0]     mplier;
  logic [QTY_W-1:0]     t_qty;
  logic                 t_buy;
  logic                 t_conflict;
  logic [PRICE_W-1:0]   price_reg;
  logic [PRICE_W-1:0]   pend_price;
  logic                 pend_flag;
  logic [CASH_W-1:0]    cash_q;
  logic [SHR_W-1:0]     shares_q;
  logic [NET_W-1:0]     net_q;
  logic                 busy_q;
  logic                 ok_q;
  logic                 rej_q;

  // Datapath helpers
  logic [ACC_W-1:0]     acc_sum;
  logic                 have_price;
  logic [PRICE_W-1:0]   new_price;
  logic [PRICE_W-1:0]   eff_price;
  logic                 req;
  logic [COST_W-1:0]    cost;
  logic                 buy_ok;
  logic                 sell_ok;
  logic                 accept;
  logic [CASH_W-1:0]    cash_nxt;
  logic [SHR_W-1:0]     shares_nxt;

  // A newer pulse wins over a parked price when both are present in IDLE.
  always_comb begin
    acc_sum    = acc + (mplier[0] ? mcand : ACC_W'(0));
    have_price = bus.price_valid | pend_flag;
    new_price  = bus.price_valid ? bus.price : pend_price;
    eff_price  = have_price ? new_price : price_reg;
    req        = bus.buy_req | bus.sell_req;
  end

  always_comb begin
    cost       = acc[COST_W-1:0];
    buy_ok     = (CASH_W'(cost) <= cash_q) &&
                 ((9'(shares_q) + 9'(t_qty)) <= 9'd255);
    sell_ok    = (SHR_W'(t_qty) <= shares_q) &&
                 ((NET_W'(cash_q) + NET_W'(cost)) <= NET_W'(65535));
    accept     = !t_conflict && (t_qty != '0) && (t_buy ? buy_ok : sell_ok);
    cash_nxt   = cash_q;
    shares_nxt = shares_q;
    if (t_buy) begin
      cash_nxt   = cash_q - CASH_W'(cost);
      shares_nxt = shares_q + SHR_W'(t_qty);
    end else begin
      cash_nxt   = cash_q + CASH_W'(cost);
      shares_nxt = shares_q - SHR_W'(t_qty);
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      t_qty      <= '0;
      t_buy      <= 1'b0;
      t_conflict <= 1'b0;
      price_reg  <= '0;
      pend_price <= '0;
      pend_flag  <= 1'b0;
      cash_q     <= START_CASH;
      shares_q   <= '0;
      net_q      <= NET_W'(START_CASH);
      busy_q     <= 1'b0;
      ok_q       <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      ok_q  <= 1'b0;
      rej_q <= 1'b0;

      // Prices arriving mid-operation are parked, never fed to live operands.
      if (state != IDLE && bus.price_valid) begin
        pend_price <= bus.price;
        pend_flag  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (have_price) begin
            price_reg <= new_price;
            pend_flag <= 1'b0;
          end
          if (req) begin
            t_qty      <= bus.qty;
            t_buy      <= bus.buy_req;
            t_conflict <= bus.buy_req & bus.sell_req;
            acc        <= '0;
            mcand      <= ACC_W'(eff_price);
            mplier     <= (bus.buy_req & bus.sell_req) ? '0 : SHR_W'(bus.qty);
            cnt        <= '0;
            busy_q     <= 1'b1;
            state      <= MUL_TRADE;
          end else if (have_price) begin
            acc    <= '0;
            mcand  <= ACC_W'(new_price);
            mplier <= shares_q;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= VALUE;
          end
        end

        MUL_TRADE: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd3) state <= DECIDE;
        end

        DECIDE: begin
          if (accept) begin
            cash_q   <= cash_nxt;
            shares_q <= shares_nxt;
            ok_q     <= 1'b1;
            acc      <= '0;
            mcand    <= ACC_W'(price_reg);
            mplier   <= shares_nxt;
            cnt      <= '0;
            state    <= VALUE;
          end else begin
            rej_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        VALUE: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            net_q  <= NET_W'(cash_q) + NET_W'(acc_sum);
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.trade_ok     = ok_q;
  assign bus.trade_reject = rej_q;
  assign bus.cash         = cash_q;
  assign bus.shares       = shares_q;
  assign bus.net_worth    = net_q;

endmodule

// File: tb/tb_portfolio_ledger.sv
// Directed bench for portfolio_ledger: trade table plus pending-price and reset sequences.
module tb_portfolio_ledger;

  logic clock_50;
  logic reset;
  int   checks;
  int   passes;

  portfolio_ledger_if bus ();

  portfolio_ledger #(.START_CASH(16'd1000)) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  typedef struct {
    logic       pen;
    logic [7:0] price;
    logic       buy;
    logic       sell;
    logic [3:0] qty;
    logic       ok;
    int         pnet;
    int         cash;
    int         shares;
    int         net;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic pulses(input string name, input int exp);
    chk(name, int'({bus.trade_ok, bus.trade_reject}), exp);
  endtask

  task automatic request(input logic b, input logic s, input logic [3:0] q);
    bus.buy_req  = b;
    bus.sell_req = s;
    bus.qty      = q;
    tick();
    bus.buy_req  = 1'b0;
    bus.sell_req = 1'b0;
  endtask

  task automatic set_price(input logic [7:0] p);
    bus.price       = p;
    bus.price_valid = 1'b1;
    tick();
    bus.price_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    bus.price_valid = 1'b0;
    bus.price       = '0;
    bus.buy_req     = 1'b0;
    bus.sell_req    = 1'b0;
    bus.qty         = '0;
    reset           = 1'b0;

    //          pen   price   buy   sell  qty   ok    pnet   cash  shr  net
    vt[0]  = '{1'b1, 8'd200, 1'b1, 1'b0, 4'd6,  1'b0, 1000,  1000, 0,  1000};
    vt[1]  = '{1'b1, 8'd50,  1'b1, 1'b0, 4'd4,  1'b1, 1000,  800,  4,  1000};
    vt[2]  = '{1'b0, 8'd0,   1'b0, 1'b1, 4'd5,  1'b0, 0,     800,  4,  1000};
    vt[3]  = '{1'b0, 8'd0,   1'b1, 1'b1, 4'd1,  1'b0, 0,     800,  4,  1000};
    vt[4]  = '{1'b0, 8'd0,   1'b1, 1'b0, 4'd0,  1'b0, 0,     800,  4,  1000};
    vt[5]  = '{1'b0, 8'd0,   1'b0, 1'b1, 4'd0,  1'b0, 0,     800,  4,  1000};
    vt[6]  = '{1'b1, 8'd100, 1'b0, 1'b1, 4'd2,  1'b1, 1200,  1000, 2,  1200};
    vt[7]  = '{1'b0, 8'd0,   1'b1, 1'b0, 4'd15, 1'b0, 0,     1000, 2,  1200};
    vt[8]  = '{1'b1, 8'd10,  1'b1, 1'b0, 4'd15, 1'b1, 1020,  850,  17, 1020};
    vt[9]  = '{1'b1, 8'd85,  1'b1, 1'b0, 4'd10, 1'b1, 2295,  0,    27, 2295};
    vt[10] = '{1'b0, 8'd0,   1'b1, 1'b0, 4'd1,  1'b0, 0,     0,    27, 2295};
    vt[11] = '{1'b1, 8'd0,   1'b1, 1'b0, 4'd15, 1'b1, 0,     0,    42, 0};
    vt[12] = '{1'b1, 8'd255, 1'b0, 1'b1, 4'd15, 1'b1, 10710, 3825, 27, 10710};
    vt[13] = '{1'b0, 8'd0,   1'b0, 1'b1, 4'd15, 1'b1, 0,     7650, 12, 10710};

    // Reset state
    repeat (2) tick();
    chk("rst_cash", int'(bus.cash), 1000);
    chk("rst_shares", int'(bus.shares), 0);
    chk("rst_net", int'(bus.net_worth), 1000);
    chk("rst_busy", int'(bus.busy), 0);
    pulses("rst_pulses", 0);
    reset = 1'b1;
    tick();
    chk("rel_cash", int'(bus.cash), 1000);
    chk("rel_busy", int'(bus.busy), 0);
    pulses("rel_pulses", 0);

    // Table-driven trades
    for (int i = 0; i < NV; i++) begin
      if (vt[i].pen) begin
        set_price(vt[i].price);          // now M+1
        repeat (7) tick();               // M+8
        chk($sformatf("v%0d_pbusy_m8", i), int'(bus.busy), 1);
        tick();                          // M+9
        chk($sformatf("v%0d_pbusy_m9", i), int'(bus.busy), 0);
        chk($sformatf("v%0d_pnet", i), int'(bus.net_worth), vt[i].pnet);
      end
      request(vt[i].buy, vt[i].sell, vt[i].qty);  // N+1
      repeat (4) tick();                          // N+5
      pulses($sformatf("v%0d_pulse_n5", i), 0);
      tick();                                     // N+6
      pulses($sformatf("v%0d_pulse_n6", i), vt[i].ok ? 2 : 1);
      chk($sformatf("v%0d_busy_n6", i), int'(bus.busy), int'(vt[i].ok));
      chk($sformatf("v%0d_cash", i), int'(bus.cash), vt[i].cash);
      chk($sformatf("v%0d_shares", i), int'(bus.shares), vt[i].shares);
      tick();                                     // N+7
      pulses($sformatf("v%0d_pulse_n7", i), 0);
      if (vt[i].ok) begin
        repeat (6) tick();                        // N+13
        chk($sformatf("v%0d_busy_n13", i), int'(bus.busy), 1);
        tick();                                   // N+14
        chk($sformatf("v%0d_busy_n14", i), int'(bus.busy), 0);
      end
      chk($sformatf("v%0d_net", i), int'(bus.net_worth), vt[i].net);
    end

    // Price arriving mid-trade is parked, then revalued after the trade
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    set_price(8'd50);
    repeat (8) tick();                   // back in IDLE
    request(1'b1, 1'b0, 4'd4);           // N+1
    tick();                              // N+2
    tick();                              // N+3
    set_price(8'd60);                    // pulse at N+3, now N+4
    tick();                              // N+5
    tick();                              // N+6
    pulses("pend_pulse_n6", 2);
    chk("pend_cash", int'(bus.cash), 800);
    chk("pend_shares", int'(bus.shares), 4);
    tick();                              // N+7
    request(1'b0, 1'b1, 4'd1);           // ignored sell at N+7, now N+8
    repeat (6) tick();                   // N+14
    chk("pend_busy_n14", int'(bus.busy), 0);
    chk("pend_net_n14", int'(bus.net_worth), 1000);
    tick();                              // N+15
    chk("pend_busy_n15", int'(bus.busy), 1);
    pulses("busy_req_ignored", 0);
    repeat (7) tick();                   // N+22
    chk("pend_busy_n22", int'(bus.busy), 1);
    tick();                              // N+23
    chk("pend_busy_n23", int'(bus.busy), 0);
    chk("pend_net_n23", int'(bus.net_worth), 1040);
    chk("ignored_sell_shares", int'(bus.shares), 4);
    chk("ignored_sell_cash", int'(bus.cash), 800);

    // Reset in the middle of an accepted buy
    request(1'b1, 1'b0, 4'd4);           // N+1 (cost 240 at price 60)
    tick();                              // N+2
    tick();                              // N+3
    #2 reset = 1'b0;
    #1;
    chk("midrst_cash", int'(bus.cash), 1000);
    chk("midrst_shares", int'(bus.shares), 0);
    chk("midrst_net", int'(bus.net_worth), 1000);
    chk("midrst_busy", int'(bus.busy), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      pulses($sformatf("midrst_nopulse%0d", k), 0);
    end
    reset = 1'b1;
    tick();
    request(1'b1, 1'b0, 4'd3);           // N'+1, price_reg back to 0
    repeat (4) tick();                   // N'+5
    pulses("post_rst_n5", 0);
    tick();                              // N'+6
    pulses("post_rst_n6", 2);
    chk("post_rst_cash", int'(bus.cash), 1000);
    chk("post_rst_shares", int'(bus.shares), 3);
    repeat (8) tick();                   // N'+14
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_net", int'(bus.net_worth), 1000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/portfolio_ledger.md
PORTFOLIO_LEDGER -- requirements
Module: portfolio_ledger

Interface
REQ-001 Parameter START_CASH, default 16'd1000, cash balance loaded at reset.
REQ-002 clock_50  in  1  system clock, 50 MHz, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; one clock, no other reset source.
REQ-004 price_valid  in  1  one-cycle pulse: new stock price present on price.
REQ-005 price  in  8  unsigned stock price from the price generator.
REQ-006 buy_req  in  1  one-cycle pulse: buy qty shares.
REQ-007 sell_req  in  1  one-cycle pulse: sell qty shares.
REQ-008 qty  in  4  unsigned share count for the trade, sampled with the request.
REQ-009 busy  out  1  high while any state other than IDLE is active.
REQ-010 trade_ok  out  1  one-cycle pulse: trade executed.
REQ-011 trade_reject  out  1  one-cycle pulse: trade refused, no state change.
REQ-012 cash  out  16  unsigned cash balance.
REQ-013 shares  out  8  unsigned shares held.
REQ-014 net_worth  out  17  cash + shares*price_reg, exact; the width covers the maximum of 130560.

Function
REQ-015 FSM states: IDLE, MUL_TRADE, DECIDE, VALUE, all held in registers.
REQ-016 price_reg: an internal 8-bit register that latches price on price_valid.
REQ-017 Multiplies use a shift-add datapath, one bit per cycle, with no combinational multiplier.
REQ-018 Request flow:
- A request seen in IDLE at cycle N latches qty and direction, then runs MUL_TRADE at N+1..N+4 to form cost = qty*price_reg (12 bits).
- DECIDE runs at N+5.
REQ-019 Buy is accepted when cost <= cash and shares+qty <= 255; otherwise it is rejected.
REQ-020 Sell is accepted when qty <= shares and cash+cost <= 65535; otherwise it is rejected.
REQ-021 qty==0 is always rejected.
REQ-022 On accept:
- cash and shares are updated, visible from N+6.
- trade_ok is high only at N+6.
- VALUE runs at N+6..N+13, computing shares*price_reg over 8 iterations.
- net_worth is updated and busy falls at N+14.
REQ-023 On reject: trade_reject is high only at N+6, cash, shares and net_worth are unchanged, and FSM returns to IDLE with busy low at N+6.
REQ-024 buy_req and sell_req high together in IDLE produce a reject at N+6, with no multiply and no change.
REQ-025 price_valid in IDLE at cycle M, with no request: latch price_reg, run VALUE at M+1..M+8, update net_worth and drop busy at M+9.
REQ-026 price_valid with a request in the same IDLE cycle: latch the price first, then run the trade at the new price; the normal trade timing applies.
REQ-027 price_valid while busy:
- The value goes to a pending register and sets a pending flag; a later pulse overwrites the pending value.
- The active multiply operands are not disturbed.
- On return to IDLE with the flag set, price_reg takes the pending value, the flag clears and VALUE restarts, per REQ-025 timing from that cycle.
REQ-028 buy_req and sell_req while busy are ignored: no queuing, no pulse.
REQ-029 trade_ok and trade_reject are never high together and never high for more than one cycle.
REQ-030 cash never wraps; any overflow or underflow condition causes a reject.

Reset
REQ-031 When reset is low, asynchronously set:
- cash=START_CASH, shares=0, net_worth=START_CASH.
- price_reg=0, pending flag=0.
- busy=0, trade_ok=0, trade_reject=0.
- FSM=IDLE.
REQ-032 Reset in mid-operation aborts the operation, emits no pulse and applies no partial update; the first request after release follows REQ-018.

Verification
REQ-033 Release reset with START_CASH=1000 -> cash=1000, shares=0, net_worth=1000, busy=0, no pulses.
REQ-034 price=50 valid, wait for idle, buy qty=4 at N -> trade_ok at N+6, cash=800, shares=4; net_worth=1000 at N+14.
REQ-035 price=200, cash=1000, buy qty=6 -> trade_reject at N+6, cash=1000, shares=0, busy low at N+6.
REQ-036 Sell qty=5 with shares=4 -> reject; buy and sell in the same cycle -> reject; qty=0 -> reject; no state change in any case.
REQ-037 Holding 4 shares at price 50, then price_valid with price=60 at N+3 during a trade -> after trade completion, VALUE reruns and net_worth reflects price 60.
REQ-038 Assert reset at N+3 of an accepted buy -> reset values immediately, no trade_ok; a new buy after release completes at N'+6.
